// File: rtl/axilite4_pkg.sv
// axilite4_pkg: shared widths, FSM/target encodings and default decode-error message for the AXI-Lite demux
package axilite4_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int STRB_W = 16;
  localparam int MSG_W  = 32;
  localparam logic [MSG_W-1:0] DECERR_MSG_DFLT = 32'h0000_0003;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_ERR} state_t;
  typedef enum logic [1:0] {TGT_S0, TGT_S1, TGT_ERR} tgt_t;
endpackage

// File: rtl/axilite4_addr_decoder.sv
// axilite4_addr_decoder: maps an address to S0/S1/ERR; S0 takes priority when both ranges match
//   i_addr : address to decode
//   o_tgt  : decoded target
module axilite4_addr_decoder
  import axilite4_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE0_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] SLAVE0_MASK = 32'hFFFF_0000,
  parameter logic [ADDR_W-1:0] SLAVE1_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLAVE1_MASK = 32'hF000_0000
) (
  input  logic [ADDR_W-1:0] i_addr,
  output tgt_t              o_tgt
);
  always_comb
    o_tgt = ((i_addr & SLAVE0_MASK) == SLAVE0_BASE) ? TGT_S0 :
            ((i_addr & SLAVE1_MASK) == SLAVE1_BASE) ? TGT_S1 : TGT_ERR;
endmodule

// File: rtl/axilite4_demux.sv
// axilite4_demux: AXI-Lite 1-to-2 address demux with local decode-error completion
//   clk, rst        : clock, async active-high reset
//   master_*        : upstream read/write channels (from the bus mux)
//   slave_0_*, slave_1_* : downstream read/write channels
module axilite4_demux
  import axilite4_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE0_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] SLAVE0_MASK = 32'hFFFF_0000,
  parameter logic [ADDR_W-1:0] SLAVE1_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLAVE1_MASK = 32'hF000_0000,
  parameter logic [MSG_W-1:0]  DECERR_MSG  = DECERR_MSG_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] master_readAddr_addr,
  input  logic              master_readAddr_valid,
  output logic              master_readAddr_ready,
  output logic [DATA_W-1:0] master_readData_data,
  output logic              master_readData_valid,
  input  logic              master_readData_ready,
  input  logic [ADDR_W-1:0] master_writeAddr_addr,
  input  logic              master_writeAddr_valid,
  output logic              master_writeAddr_ready,
  input  logic [DATA_W-1:0] master_writeData_data,
  input  logic [STRB_W-1:0] master_writeData_strb,
  input  logic              master_writeData_valid,
  output logic              master_writeData_ready,
  output logic [MSG_W-1:0]  master_writeResp_msg,
  output logic              master_writeResp_valid,
  input  logic              master_writeResp_ready,
  output logic [ADDR_W-1:0] slave_0_readAddr_addr,
  output logic              slave_0_readAddr_valid,
  input  logic              slave_0_readAddr_ready,
  input  logic [DATA_W-1:0] slave_0_readData_data,
  input  logic              slave_0_readData_valid,
  output logic              slave_0_readData_ready,
  output logic [ADDR_W-1:0] slave_0_writeAddr_addr,
  output logic              slave_0_writeAddr_valid,
  input  logic              slave_0_writeAddr_ready,
  output logic [DATA_W-1:0] slave_0_writeData_data,
  output logic [STRB_W-1:0] slave_0_writeData_strb,
  output logic              slave_0_writeData_valid,
  input  logic              slave_0_writeData_ready,
  input  logic [MSG_W-1:0]  slave_0_writeResp_msg,
  input  logic              slave_0_writeResp_valid,
  output logic              slave_0_writeResp_ready,
  output logic [ADDR_W-1:0] slave_1_readAddr_addr,
  output logic              slave_1_readAddr_valid,
  input  logic              slave_1_readAddr_ready,
  input  logic [DATA_W-1:0] slave_1_readData_data,
  input  logic              slave_1_readData_valid,
  output logic              slave_1_readData_ready,
  output logic [ADDR_W-1:0] slave_1_writeAddr_addr,
  output logic              slave_1_writeAddr_valid,
  input  logic              slave_1_writeAddr_ready,
  output logic [DATA_W-1:0] slave_1_writeData_data,
  output logic [STRB_W-1:0] slave_1_writeData_strb,
  output logic              slave_1_writeData_valid,
  input  logic              slave_1_writeData_ready,
  input  logic [MSG_W-1:0]  slave_1_writeResp_msg,
  input  logic              slave_1_writeResp_valid,
  output logic              slave_1_writeResp_ready
);
  state_t r_rd_st, w_rd_nxt, r_wr_st, w_wr_nxt;
  tgt_t   r_rd_tgt, r_wr_tgt, w_rd_dec, w_wr_dec;
  logic   w_rd_req, w_rd_resp, w_rd_err, w_r0, w_r1;
  logic   w_wr_req, w_wr_resp, w_wr_err, w_w0, w_w1, w_wr_both, w_wr_go;
  axilite4_addr_decoder #(.SLAVE0_BASE(SLAVE0_BASE), .SLAVE0_MASK(SLAVE0_MASK),
    .SLAVE1_BASE(SLAVE1_BASE), .SLAVE1_MASK(SLAVE1_MASK))
    u_rd_dec (.i_addr(master_readAddr_addr), .o_tgt(w_rd_dec));
  axilite4_addr_decoder #(.SLAVE0_BASE(SLAVE0_BASE), .SLAVE0_MASK(SLAVE0_MASK),
    .SLAVE1_BASE(SLAVE1_BASE), .SLAVE1_MASK(SLAVE1_MASK))
    u_wr_dec (.i_addr(master_writeAddr_addr), .o_tgt(w_wr_dec));
  assign w_rd_req  = r_rd_st == ST_REQ;
  assign w_rd_resp = r_rd_st == ST_RESP;
  assign w_rd_err  = r_rd_st == ST_ERR;
  assign w_r0      = r_rd_tgt == TGT_S0;
  assign w_r1      = r_rd_tgt == TGT_S1;
  assign w_wr_req  = r_wr_st == ST_REQ;
  assign w_wr_resp = r_wr_st == ST_RESP;
  assign w_wr_err  = r_wr_st == ST_ERR;
  assign w_w0      = r_wr_tgt == TGT_S0;
  assign w_w1      = r_wr_tgt == TGT_S1;
  // Address and data must handshake in the same cycle, so the slave only sees
  // valid once both master halves are present, and the master sees ready only
  // once both slave halves (or the local error sink) accept.
  assign w_wr_both = master_writeAddr_valid & master_writeData_valid;
  assign w_wr_go   = w_wr_req & w_wr_both &
                     (w_w0 ? slave_0_writeAddr_ready & slave_0_writeData_ready :
                      w_w1 ? slave_1_writeAddr_ready & slave_1_writeData_ready : 1'b1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd_st  <= ST_IDLE;
      r_rd_tgt <= TGT_S0;
      r_wr_st  <= ST_IDLE;
      r_wr_tgt <= TGT_S0;
    end else begin
      r_rd_st <= w_rd_nxt;
      r_wr_st <= w_wr_nxt;
      if (r_rd_st == ST_IDLE && master_readAddr_valid) r_rd_tgt <= w_rd_dec;
      if (r_wr_st == ST_IDLE && master_writeAddr_valid) r_wr_tgt <= w_wr_dec;
    end
  always_comb begin
    w_rd_nxt = (r_rd_st == ST_IDLE && master_readAddr_valid) ? ST_REQ :
               (w_rd_req && master_readAddr_valid && master_readAddr_ready) ?
                 (r_rd_tgt == TGT_ERR ? ST_ERR : ST_RESP) :
               ((w_rd_resp || w_rd_err) && master_readData_valid && master_readData_ready) ?
                 ST_IDLE : r_rd_st;
    w_wr_nxt = (r_wr_st == ST_IDLE && master_writeAddr_valid) ? ST_REQ :
               w_wr_go ? (r_wr_tgt == TGT_ERR ? ST_ERR : ST_RESP) :
               ((w_wr_resp || w_wr_err) && master_writeResp_valid && master_writeResp_ready) ?
                 ST_IDLE : r_wr_st;
  end
  always_comb begin
    slave_0_readAddr_valid = w_rd_req & w_r0 & master_readAddr_valid;
    slave_1_readAddr_valid = w_rd_req & w_r1 & master_readAddr_valid;
    slave_0_readAddr_addr  = (w_rd_req & w_r0) ? master_readAddr_addr : '0;
    slave_1_readAddr_addr  = (w_rd_req & w_r1) ? master_readAddr_addr : '0;
    master_readAddr_ready  = w_rd_req & (w_r0 ? slave_0_readAddr_ready :
                                         w_r1 ? slave_1_readAddr_ready : 1'b1);
    master_readData_valid  = w_rd_err | (w_rd_resp & (w_r0 ? slave_0_readData_valid : slave_1_readData_valid));
    master_readData_data   = w_rd_resp ? (w_r0 ? slave_0_readData_data : slave_1_readData_data) : '0;
    slave_0_readData_ready = w_rd_resp & w_r0 & master_readData_ready;
    slave_1_readData_ready = w_rd_resp & w_r1 & master_readData_ready;
  end
  always_comb begin
    slave_0_writeAddr_valid = w_wr_req & w_w0 & w_wr_both;
    slave_1_writeAddr_valid = w_wr_req & w_w1 & w_wr_both;
    slave_0_writeData_valid = w_wr_req & w_w0 & w_wr_both;
    slave_1_writeData_valid = w_wr_req & w_w1 & w_wr_both;
    slave_0_writeAddr_addr  = (w_wr_req & w_w0) ? master_writeAddr_addr : '0;
    slave_1_writeAddr_addr  = (w_wr_req & w_w1) ? master_writeAddr_addr : '0;
    slave_0_writeData_data  = (w_wr_req & w_w0) ? master_writeData_data : '0;
    slave_1_writeData_data  = (w_wr_req & w_w1) ? master_writeData_data : '0;
    slave_0_writeData_strb  = (w_wr_req & w_w0) ? master_writeData_strb : '0;
    slave_1_writeData_strb  = (w_wr_req & w_w1) ? master_writeData_strb : '0;
    master_writeAddr_ready  = w_wr_go;
    master_writeData_ready  = w_wr_go;
    master_writeResp_valid  = w_wr_err | (w_wr_resp & (w_w0 ? slave_0_writeResp_valid : slave_1_writeResp_valid));
    master_writeResp_msg    = w_wr_resp ? (w_w0 ? slave_0_writeResp_msg : slave_1_writeResp_msg) :
                              w_wr_err ? DECERR_MSG : '0;
    slave_0_writeResp_ready = w_wr_resp & w_w0 & master_writeResp_ready;
    slave_1_writeResp_ready = w_wr_resp & w_w1 & master_writeResp_ready;
  end
endmodule

// File: tb/tb_axilite4_demux.sv
// tb_axilite4_demux: directed and randomized checks of the AXI-Lite demux against an address-map model
module tb_axilite4_demux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] m_ar_addr, m_aw_addr;
  logic m_ar_valid, m_r_ready, m_aw_valid, m_w_valid, m_b_ready;
  logic [127:0] m_w_data;
  logic [15:0] m_w_strb;
  wire m_ar_ready, m_r_valid, m_aw_ready, m_w_ready, m_b_valid;
  wire [127:0] m_r_data;
  wire [31:0] m_b_msg;
  logic [1:0] s_ar_ready, s_r_valid, s_aw_ready, s_w_ready, s_b_valid;
  logic [1:0][127:0] s_r_data;
  logic [1:0][31:0] s_b_msg;
  wire [1:0] s_ar_valid, s_r_ready, s_aw_valid, s_w_valid, s_b_ready;
  wire [1:0][31:0] s_ar_addr, s_aw_addr;
  wire [1:0][127:0] s_w_data;
  wire [1:0][15:0] s_w_strb;
  wire ov_m_ar_ready, ov_m_r_valid, ov_m_aw_ready, ov_m_w_ready, ov_m_b_valid;
  wire [127:0] ov_m_r_data;
  wire [31:0] ov_m_b_msg;
  wire [1:0] ov_s_ar_valid, ov_s_r_ready, ov_s_aw_valid, ov_s_w_valid, ov_s_b_ready;
  wire [1:0][31:0] ov_s_ar_addr, ov_s_aw_addr;
  wire [1:0][127:0] ov_s_w_data;
  wire [1:0][15:0] ov_s_w_strb;

  always #5 clk = ~clk;

  axilite4_demux dut (
    .clk(clk), .rst(rst),
    .master_readAddr_addr(m_ar_addr), .master_readAddr_valid(m_ar_valid), .master_readAddr_ready(m_ar_ready),
    .master_readData_data(m_r_data), .master_readData_valid(m_r_valid), .master_readData_ready(m_r_ready),
    .master_writeAddr_addr(m_aw_addr), .master_writeAddr_valid(m_aw_valid), .master_writeAddr_ready(m_aw_ready),
    .master_writeData_data(m_w_data), .master_writeData_strb(m_w_strb), .master_writeData_valid(m_w_valid),
    .master_writeData_ready(m_w_ready),
    .master_writeResp_msg(m_b_msg), .master_writeResp_valid(m_b_valid), .master_writeResp_ready(m_b_ready),
    .slave_0_readAddr_addr(s_ar_addr[0]), .slave_0_readAddr_valid(s_ar_valid[0]), .slave_0_readAddr_ready(s_ar_ready[0]),
    .slave_0_readData_data(s_r_data[0]), .slave_0_readData_valid(s_r_valid[0]), .slave_0_readData_ready(s_r_ready[0]),
    .slave_0_writeAddr_addr(s_aw_addr[0]), .slave_0_writeAddr_valid(s_aw_valid[0]), .slave_0_writeAddr_ready(s_aw_ready[0]),
    .slave_0_writeData_data(s_w_data[0]), .slave_0_writeData_strb(s_w_strb[0]), .slave_0_writeData_valid(s_w_valid[0]),
    .slave_0_writeData_ready(s_w_ready[0]),
    .slave_0_writeResp_msg(s_b_msg[0]), .slave_0_writeResp_valid(s_b_valid[0]), .slave_0_writeResp_ready(s_b_ready[0]),
    .slave_1_readAddr_addr(s_ar_addr[1]), .slave_1_readAddr_valid(s_ar_valid[1]), .slave_1_readAddr_ready(s_ar_ready[1]),
    .slave_1_readData_data(s_r_data[1]), .slave_1_readData_valid(s_r_valid[1]), .slave_1_readData_ready(s_r_ready[1]),
    .slave_1_writeAddr_addr(s_aw_addr[1]), .slave_1_writeAddr_valid(s_aw_valid[1]), .slave_1_writeAddr_ready(s_aw_ready[1]),
    .slave_1_writeData_data(s_w_data[1]), .slave_1_writeData_strb(s_w_strb[1]), .slave_1_writeData_valid(s_w_valid[1]),
    .slave_1_writeData_ready(s_w_ready[1]),
    .slave_1_writeResp_msg(s_b_msg[1]), .slave_1_writeResp_valid(s_b_valid[1]), .slave_1_writeResp_ready(s_b_ready[1])
  );

  axilite4_demux #(.SLAVE1_BASE(32'h0), .SLAVE1_MASK(32'h0)) dut_ov (
    .clk(clk), .rst(rst),
    .master_readAddr_addr(m_ar_addr), .master_readAddr_valid(m_ar_valid), .master_readAddr_ready(ov_m_ar_ready),
    .master_readData_data(ov_m_r_data), .master_readData_valid(ov_m_r_valid), .master_readData_ready(m_r_ready),
    .master_writeAddr_addr(m_aw_addr), .master_writeAddr_valid(m_aw_valid), .master_writeAddr_ready(ov_m_aw_ready),
    .master_writeData_data(m_w_data), .master_writeData_strb(m_w_strb), .master_writeData_valid(m_w_valid),
    .master_writeData_ready(ov_m_w_ready),
    .master_writeResp_msg(ov_m_b_msg), .master_writeResp_valid(ov_m_b_valid), .master_writeResp_ready(m_b_ready),
    .slave_0_readAddr_addr(ov_s_ar_addr[0]), .slave_0_readAddr_valid(ov_s_ar_valid[0]), .slave_0_readAddr_ready(s_ar_ready[0]),
    .slave_0_readData_data(s_r_data[0]), .slave_0_readData_valid(s_r_valid[0]), .slave_0_readData_ready(ov_s_r_ready[0]),
    .slave_0_writeAddr_addr(ov_s_aw_addr[0]), .slave_0_writeAddr_valid(ov_s_aw_valid[0]), .slave_0_writeAddr_ready(s_aw_ready[0]),
    .slave_0_writeData_data(ov_s_w_data[0]), .slave_0_writeData_strb(ov_s_w_strb[0]), .slave_0_writeData_valid(ov_s_w_valid[0]),
    .slave_0_writeData_ready(s_w_ready[0]),
    .slave_0_writeResp_msg(s_b_msg[0]), .slave_0_writeResp_valid(s_b_valid[0]), .slave_0_writeResp_ready(ov_s_b_ready[0]),
    .slave_1_readAddr_addr(ov_s_ar_addr[1]), .slave_1_readAddr_valid(ov_s_ar_valid[1]), .slave_1_readAddr_ready(s_ar_ready[1]),
    .slave_1_readData_data(s_r_data[1]), .slave_1_readData_valid(s_r_valid[1]), .slave_1_readData_ready(ov_s_r_ready[1]),
    .slave_1_writeAddr_addr(ov_s_aw_addr[1]), .slave_1_writeAddr_valid(ov_s_aw_valid[1]), .slave_1_writeAddr_ready(s_aw_ready[1]),
    .slave_1_writeData_data(ov_s_w_data[1]), .slave_1_writeData_strb(ov_s_w_strb[1]), .slave_1_writeData_valid(ov_s_w_valid[1]),
    .slave_1_writeData_ready(s_w_ready[1]),
    .slave_1_writeResp_msg(s_b_msg[1]), .slave_1_writeResp_valid(s_b_valid[1]), .slave_1_writeResp_ready(ov_s_b_ready[1])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Address map of the default instance: 0 = slave 0, 1 = slave 1, 2 = unmapped
  function automatic int tgt_of(input logic [31:0] a);
    if (a[31:16] == 16'h0000) return 0;
    if (a[31:28] == 4'h8) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 3);
    return r == 0 ? {16'h0, 16'($urandom)} : r == 1 ? {4'h8, 28'($urandom)} :
           r == 2 ? {4'h4, 28'($urandom)} : 32'($urandom);
  endfunction

  function automatic logic [1:0] onehot(input int t);
    return t == 0 ? 2'b01 : t == 1 ? 2'b10 : 2'b00;
  endfunction

  task automatic do_read(input logic [31:0] a, input logic [127:0] d, input int dar, input int dr);
    int t;
    t = tgt_of(a);
    m_ar_addr = a;
    m_ar_valid = 1'b1;
    #1;
    chk("rd_idle_ready", m_ar_ready, 0);
    chk("rd_idle_svalid", s_ar_valid, 0);
    @(negedge clk);
    for (int i = 0; i <= (t == 2 ? 0 : dar); i++) begin
      if (t < 2) s_ar_ready[t] = (i == dar);
      #1;
      chk("rd_req_svalid", s_ar_valid, onehot(t));
      chk("rd_req_saddr", s_ar_addr, t == 0 ? {32'h0, a} : t == 1 ? {a, 32'h0} : 64'h0);
      chk("rd_req_mready", m_ar_ready, t == 2 || i == dar);
      @(negedge clk);
    end
    m_ar_valid = 1'b0;
    m_ar_addr = '0;
    s_ar_ready = '0;
    m_r_ready = 1'b1;
    for (int i = 0; i <= (t == 2 ? 0 : dr); i++) begin
      if (t < 2) begin
        s_r_valid[t] = (i == dr);
        s_r_data[t] = d;
      end
      #1;
      chk("rd_resp_mvalid", m_r_valid, t == 2 || i == dr);
      if (t == 2 || i == dr) chk("rd_resp_mdata", m_r_data, t == 2 ? 128'h0 : d);
      chk("rd_resp_sready", s_r_ready, onehot(t));
      @(negedge clk);
    end
    s_r_valid = '0;
    s_r_data = '0;
    m_r_ready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s,
                          input logic [31:0] msg, input int daw, input int db);
    int t;
    t = tgt_of(a);
    m_aw_addr = a;
    m_w_data = d;
    m_w_strb = s;
    m_aw_valid = 1'b1;
    m_w_valid = 1'b1;
    #1;
    chk("wr_idle_ready", {m_aw_ready, m_w_ready}, 0);
    chk("wr_idle_svalid", s_aw_valid, 0);
    @(negedge clk);
    for (int i = 0; i <= (t == 2 ? 0 : daw); i++) begin
      if (t < 2) begin
        s_w_ready[t] = 1'b1;
        s_aw_ready[t] = (i == daw);
      end
      #1;
      chk("wr_req_svalid", {s_aw_valid, s_w_valid}, {onehot(t), onehot(t)});
      chk("wr_req_saddr", s_aw_addr, t == 0 ? {32'h0, a} : t == 1 ? {a, 32'h0} : 64'h0);
      chk("wr_req_sdata0", s_w_data[0], t == 0 ? d : 128'h0);
      chk("wr_req_sdata1", s_w_data[1], t == 1 ? d : 128'h0);
      chk("wr_req_sstrb", s_w_strb, t == 0 ? {16'h0, s} : t == 1 ? {s, 16'h0} : 32'h0);
      chk("wr_req_mready", {m_aw_ready, m_w_ready}, (t == 2 || i == daw) ? 2'b11 : 2'b00);
      @(negedge clk);
    end
    m_aw_valid = 1'b0;
    m_w_valid = 1'b0;
    m_aw_addr = '0;
    m_w_data = '0;
    m_w_strb = '0;
    s_aw_ready = '0;
    s_w_ready = '0;
    m_b_ready = 1'b1;
    for (int i = 0; i <= (t == 2 ? 0 : db); i++) begin
      if (t < 2) begin
        s_b_valid[t] = (i == db);
        s_b_msg[t] = msg;
      end
      #1;
      chk("wr_resp_mvalid", m_b_valid, t == 2 || i == db);
      if (t == 2 || i == db) chk("wr_resp_msg", m_b_msg, t == 2 ? 32'h3 : msg);
      chk("wr_resp_sready", s_b_ready, onehot(t));
      @(negedge clk);
    end
    s_b_valid = '0;
    s_b_msg = '0;
    m_b_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    m_ar_addr = '0; m_aw_addr = '0; m_ar_valid = 0; m_r_ready = 1; m_aw_valid = 0;
    m_w_valid = 0; m_b_ready = 1; m_w_data = '0; m_w_strb = '0;
    s_ar_ready = '1; s_r_valid = '1; s_aw_ready = '1; s_w_ready = '1; s_b_valid = '1;
    s_r_data = '1; s_b_msg = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_mvalids", {m_r_valid, m_b_valid, m_ar_ready, m_aw_ready, m_w_ready}, 0);
    chk("reset_sready", {s_r_ready, s_b_ready}, 0);
    chk("reset_mdata", m_r_data, 0);
    m_r_ready = 0; m_b_ready = 0;
    s_ar_ready = '0; s_r_valid = '0; s_aw_ready = '0; s_w_ready = '0; s_b_valid = '0;
    s_r_data = '0; s_b_msg = '0;
    @(negedge clk);
    rst = 1'b0;
    // Overlapping ranges: slave 0 must win at 0x20 in the instance where slave 1 matches everything
    m_ar_addr = 32'h0000_0020;
    m_ar_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("overlap_svalid", ov_s_ar_valid, 2'b01);
    chk("overlap_saddr", ov_s_ar_addr, {32'h0, 32'h20});
    m_ar_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_read(32'h0000_0010, 128'hA5, 2, 1);
    do_write(32'h8000_0004, 128'h1234, 16'h000F, 32'h0, 0, 0);
    do_read(32'h4000_0000, 128'h0, 0, 0);
    do_write(32'h4000_0000, 128'hBEEF, 16'hFFFF, 32'h0, 0, 0);
    do_read(32'h8000_0100, 128'hCAFE_0001, 0, 0);
    do_write(32'h0000_0100, 128'h77, 16'h00F0, 32'h2, 1, 2);
    // Concurrent read to slave 0 and write to slave 1, minimum latency
    m_ar_addr = 32'h0000_0100; m_ar_valid = 1;
    m_aw_addr = 32'h8000_0040; m_aw_valid = 1; m_w_valid = 1;
    m_w_data = 128'h5555; m_w_strb = 16'hFFFF;
    @(negedge clk);
    s_ar_ready[0] = 1; s_aw_ready[1] = 1; s_w_ready[1] = 1;
    #1;
    chk("conc_req_ready", {m_ar_ready, m_aw_ready, m_w_ready}, 3'b111);
    chk("conc_req_svalid", {s_ar_valid, s_aw_valid}, 4'b0110);
    @(negedge clk);
    m_ar_valid = 0; m_aw_valid = 0; m_w_valid = 0;
    s_ar_ready = '0; s_aw_ready = '0; s_w_ready = '0;
    s_r_valid[0] = 1; s_r_data[0] = 128'h9999; s_b_valid[1] = 1; s_b_msg[1] = 32'h0;
    m_r_ready = 1; m_b_ready = 1;
    #1;
    chk("conc_resp_valid", {m_r_valid, m_b_valid}, 2'b11);
    chk("conc_resp_rdata", m_r_data, 128'h9999);
    chk("conc_resp_msg", m_b_msg, 32'h0);
    @(negedge clk);
    s_r_valid = '0; s_b_valid = '0; m_r_ready = 0; m_b_ready = 0;
    #1;
    chk("conc_idle", {m_r_valid, m_b_valid, m_ar_ready, m_aw_ready}, 0);
    // Master valid drops in REQ; target stays latched even if the address changes
    m_ar_addr = 32'h0000_0200; m_ar_valid = 1;
    @(negedge clk);
    m_ar_valid = 0;
    #1;
    chk("drop_svalid", s_ar_valid, 2'b00);
    @(negedge clk);
    m_ar_addr = 32'h4000_0000; m_ar_valid = 1; s_ar_ready[0] = 1;
    #1;
    chk("drop_hold_svalid", s_ar_valid, 2'b01);
    chk("drop_hold_addr", s_ar_addr[0], 32'h4000_0000);
    @(negedge clk);
    m_ar_valid = 0; s_ar_ready = '0; s_r_valid[0] = 1; s_r_data[0] = 128'h42; m_r_ready = 1;
    #1;
    chk("drop_resp", m_r_data, 128'h42);
    @(negedge clk);
    s_r_valid = '0; m_r_ready = 0;
    // Write waits until write data joins the address
    m_aw_addr = 32'h8000_0100; m_aw_valid = 1; m_w_valid = 0; m_w_data = 128'h31; m_w_strb = 16'h3;
    @(negedge clk);
    s_aw_ready[1] = 1; s_w_ready[1] = 1;
    #1;
    chk("wr_split_noready", {m_aw_ready, m_w_ready}, 0);
    @(negedge clk);
    m_w_valid = 1;
    #1;
    chk("wr_split_ready", {m_aw_ready, m_w_ready}, 2'b11);
    @(negedge clk);
    m_aw_valid = 0; m_w_valid = 0; s_aw_ready = '0; s_w_ready = '0;
    s_b_valid[1] = 1; s_b_msg[1] = 32'h5; m_b_ready = 1;
    #1;
    chk("wr_split_msg", m_b_msg, 32'h5);
    @(negedge clk);
    s_b_valid = '0; m_b_ready = 0;
    // Reset in RESP: outputs drop immediately, nothing is answered
    m_ar_addr = 32'h0000_0030; m_ar_valid = 1;
    @(negedge clk);
    s_ar_ready[0] = 1;
    @(negedge clk);
    m_ar_valid = 0; s_ar_ready = '0; s_r_valid[0] = 1; s_r_data[0] = 128'hDEAD; m_r_ready = 1;
    #1;
    chk("rst_pre_valid", m_r_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_valid", {m_r_valid, s_r_ready, m_ar_ready}, 0);
    chk("rst_data", m_r_data, 0);
    @(negedge clk);
    rst = 1'b0; s_r_valid = '0; s_r_data = '0; m_r_ready = 0;
    do_read(32'h0000_0040, 128'h1111, 1, 0);
    for (int n = 0; n < 40; n++) begin
      a = rand_addr();
      if ($urandom_range(0, 1) == 1)
        do_read(a, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_write(a, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
